pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Drives PC and
//  IF/ID, ID/EX, EX/MEM, MEM/WB latch enables and flushes from four sources:
//  memory waits, load-use hazards, EX-resolved redirects and halt.
//  Forwarding covers every other RAW case, so it sees only the load-use case.
//  A small FSM (RUN/DRAIN/HALTED) drains the pipe on halt. A saturating
//  counter tallies stall cycles for performance checks.
// PARAMETERS
//  CNT_W   16   width of stall_cnt
// PORTS
//  CLK          in   1      system clock, rising edge
//  nRST         in   1      asynchronous active-low reset
//  ihit         in   1      instruction fetch completes this cycle
//  dhit         in   1      data access in MEM completes this cycle
//  dmem_req_mem in   1      MEM-stage instr is a load or store
//  dmemREN_ex   in   1      EX-stage instr is a load
//  wsel_ex      in   5      EX-stage destination register
//  rs_id        in   5      ID-stage rs
//  rt_id        in   5      ID-stage rt
//  uses_rt_id   in   1      ID-stage instr reads rt
//  redirect_ex  in   1      taken branch/jump resolved in EX, PC loads target
//  halt_id      in   1      ID-stage instr is HALT
//  halt_wb      in   1      HALT has reached WB
//  pc_en        out  1      PC register update
//  ifid_en, idex_en, exmem_en, memwb_en  out 1 each  latch load enables
//  ifid_flush, idex_flush  out 1 each  latch loads NOP (honoured only when its en=1)
//  halted       out  1      pipeline fully stopped
//  stall_cnt    out  CNT_W  cycles with pc_en=0 outside HALTED, saturating
// BEHAVIOUR
//  - Reset (nRST=0, async): state=RUN, stall_cnt=0. All en=0, all flush=1,
//    halted=0, regardless of inputs.
//  - Outputs are combinational from state and inputs. State and counter
//    update on the CLK rising edge.
//  - Per-cycle priority (highest first), RUN/DRAIN:
//    1 DWAIT: dmem_req_mem & !dhit -> every en=0, flushes=0 (full freeze).
//    2 REDIRECT: redirect_ex -> all en=1, ifid_flush=1, idex_flush=1.
//      In DRAIN, this returns to RUN (the HALT was on the wrong path).
//    3 LOADUSE: dmemREN_ex & wsel_ex!=0 & (wsel_ex==rs_id |
//      (uses_rt_id & wsel_ex==rt_id)) -> pc_en=0, ifid_en=0, idex_en=1,
//      idex_flush=1, exmem_en=1, memwb_en=1. Yields exactly one bubble,
//      because the load leaves EX the next edge.
//    4 IWAIT: !ihit -> pc_en=0, ifid_en=1, ifid_flush=1, rest en=1.
//    5 otherwise: all en=1, no flush.
//  - FSM:
//    RUN -> DRAIN when halt_id in a non-DWAIT, non-REDIRECT, non-LOADUSE cycle.
//      A halt_id held by LOADUSE is re-evaluated the next cycle.
//    DRAIN: pc_en=0, ifid_flush=1 forced on top of the cases above; ihit is
//      ignored. DWAIT still freezes; REDIRECT -> RUN.
//    DRAIN -> HALTED when halt_wb=1 (and not DWAIT).
//    HALTED: all en=0, flush=0, halted=1. Exit only by reset.
//  - stall_cnt += 1 each edge where pc_en=0 and state!=HALTED.
//    Holds at 2^CNT_W-1 (no wrap).
//  - Reset mid-DRAIN or mid-DWAIT aborts immediately to the reset values.
// TESTING
//  T1 load-use: dmemREN_ex=1, wsel_ex=2, rs_id=2, ihit=1 -> pc_en=0,
//     ifid_en=0, idex_flush=1, exmem_en=1 for 1 cycle; then
//     dmemREN_ex=0 -> all en=1; stall_cnt=1.
//  T2 $zero/no-rt: wsel_ex=0, rs_id=0 -> no stall. Separately, wsel_ex=5,
//     rt_id=5, uses_rt_id=0 -> no stall.
//  T3 dmiss: dmem_req_mem=1, dhit=0 for 3 cycles (load-use also true) ->
//     all en=0 for 3 cycles, stall_cnt=3; dhit=1 -> LOADUSE outputs.
//  T4 redirect beats load-use and ihit=0 -> pc_en=1, ifid_flush=1,
//     idex_flush=1. Also: redirect_ex in DRAIN -> RUN next edge, pc_en=1.
//  T5 halt: halt_id=1 -> DRAIN. pc_en=0, ifid_flush=1 for 3 cycles;
//     halt_wb=1 -> halted=1 next edge, all en=0, stall_cnt frozen.
//     nRST pulse -> RUN, stall_cnt=0.
//  T6 CNT_W=4: ihit=0 for 20 cycles -> stall_cnt=15 (saturated, no wrap).

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: per-cycle hazard priority,
// a RUN/DRAIN/HALTED halt sequencer and a saturating stall-cycle counter.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmem_req_mem,
  input  logic             dmemREN_ex,
  input  logic [4:0]       wsel_ex,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rt_id,
  input  logic             redirect_ex,
  input  logic             halt_id,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t cur_state, nxt_state;

  logic dwait;
  logic loaduse;
  logic rs_match;
  logic rt_match;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  assign dwait    = dmem_req_mem & ~dhit;
  assign rs_match = (wsel_ex == rs_id);
  assign rt_match = uses_rt_id & (wsel_ex == rt_id);
  // $zero is never a real dependency, so a load targeting r0 never stalls.
  assign loaduse  = dmemREN_ex & (wsel_ex != 5'd0) & (rs_match | rt_match);

  assign state = cur_state;

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cur_state <= ST_RUN;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_RUN: begin
        if (!dwait && !redirect_ex && !loaduse && halt_id) begin
          nxt_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A redirect means the HALT was fetched on the wrong path.
        if (dwait) begin
          nxt_state = ST_DRAIN;
        end else if (redirect_ex) begin
          nxt_state = ST_RUN;
        end else if (halt_wb) begin
          nxt_state = ST_HALTED;
        end
      end
      ST_HALTED: nxt_state = ST_HALTED;
      default:   nxt_state = ST_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    if (!nRST) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (cur_state == ST_HALTED) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      halted   = 1'b1;
    end else if (dwait) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (redirect_ex) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      if (loaduse) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (!ihit && cur_state == ST_RUN) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
      // While draining, fetch is stopped and only bubbles enter IF/ID.
      if (cur_state == ST_DRAIN) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (!pc_en && cur_state != ST_HALTED && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazard priority, halt drain sequence,
// reset abort and stall-counter saturation (second instance with CNT_W=4).
module tb_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, dmem_req_mem, dmemREN_ex;
  logic [4:0]  wsel_ex, rs_id, rt_id;
  logic        uses_rt_id, redirect_ex, halt_id, halt_wb;

  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, halted;
  logic [15:0] stall_cnt;
  logic [1:0]  state;

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_halted;
  logic [3:0]  s_stall_cnt;
  logic [1:0]  s_state;

  int tests_run = 0;
  int tests_failed = 0;

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted}
  localparam logic [7:0] O_RST    = 8'b00000110;
  localparam logic [7:0] O_NORM   = 8'b11111000;
  localparam logic [7:0] O_LDUSE  = 8'b00111010;
  localparam logic [7:0] O_IWAIT  = 8'b01111100;
  localparam logic [7:0] O_DRAIN  = 8'b01111100;
  localparam logic [7:0] O_FREEZE = 8'b00000000;
  localparam logic [7:0] O_REDIR  = 8'b11111110;
  localparam logic [7:0] O_HALTED = 8'b00000001;

  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALTED = 2'd2;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmem_req_mem(dmem_req_mem), .dmemREN_ex(dmemREN_ex),
    .wsel_ex(wsel_ex), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .redirect_ex(redirect_ex), .halt_id(halt_id), .halt_wb(halt_wb),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .halted(halted), .stall_cnt(stall_cnt), .state(state)
  );

  pipeline_ctrl #(.CNT_W(4)) dut_small (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dmem_req_mem(dmem_req_mem), .dmemREN_ex(dmemREN_ex),
    .wsel_ex(wsel_ex), .rs_id(rs_id), .rt_id(rt_id), .uses_rt_id(uses_rt_id),
    .redirect_ex(redirect_ex), .halt_id(halt_id), .halt_wb(halt_wb),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
    .exmem_en(s_exmem_en), .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .halted(s_halted), .stall_cnt(s_stall_cnt),
    .state(s_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  function automatic logic [7:0] outs();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted};
  endfunction

  // Driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b1; dmem_req_mem = 1'b0; dmemREN_ex = 1'b0;
    wsel_ex = 5'd0; rs_id = 5'd0; rt_id = 5'd0; uses_rt_id = 1'b0;
    redirect_ex = 1'b0; halt_id = 1'b0; halt_wb = 1'b0;
  endtask

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] exp);
    check(tag, {24'd0, outs()}, {24'd0, exp});
  endtask

  initial begin
    idle_inputs();
    nRST = 1'b0;
    #2;
    check_outs("reset_outs", O_RST);
    check("reset_cnt", {16'd0, stall_cnt}, 32'd0);
    check("reset_state", {30'd0, state}, {30'd0, S_RUN});
    ihit = 1'b0; dmem_req_mem = 1'b1; dhit = 1'b0; redirect_ex = 1'b1; settle();
    check_outs("reset_ignores_inputs", O_RST);
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1;
    settle();
    check_outs("run_idle", O_NORM);

    // T1 load-use via rs
    dmemREN_ex = 1'b1; wsel_ex = 5'd2; rs_id = 5'd2; settle();
    check_outs("t1_loaduse", O_LDUSE);
    tick();
    dmemREN_ex = 1'b0; settle();
    check_outs("t1_after", O_NORM);
    check("t1_cnt", {16'd0, stall_cnt}, 32'd1);

    // T2 $zero and rt-not-used cases
    dmemREN_ex = 1'b1; wsel_ex = 5'd0; rs_id = 5'd0; settle();
    check_outs("t2_zero_reg", O_NORM);
    wsel_ex = 5'd5; rs_id = 5'd1; rt_id = 5'd5; uses_rt_id = 1'b0; settle();
    check_outs("t2_rt_unused", O_NORM);
    uses_rt_id = 1'b1; settle();
    check_outs("t2_rt_used", O_LDUSE);
    uses_rt_id = 1'b0; rt_id = 5'd0; settle();
    tick();
    check("t2_cnt", {16'd0, stall_cnt}, 32'd1);

    // T3 data miss with load-use also pending
    wsel_ex = 5'd2; rs_id = 5'd2; dmem_req_mem = 1'b1; dhit = 1'b0; settle();
    for (int i = 0; i < 3; i++) begin
      check_outs("t3_freeze", O_FREEZE);
      tick();
    end
    check("t3_cnt", {16'd0, stall_cnt}, 32'd4);
    dhit = 1'b1; settle();
    check_outs("t3_dhit_loaduse", O_LDUSE);
    tick();
    check("t3_cnt2", {16'd0, stall_cnt}, 32'd5);
    dmem_req_mem = 1'b0; dmemREN_ex = 1'b0; settle();

    // T4 redirect priority
    redirect_ex = 1'b1; dmemREN_ex = 1'b1; ihit = 1'b0; settle();
    check_outs("t4_redirect_wins", O_REDIR);
    dmem_req_mem = 1'b1; dhit = 1'b0; settle();
    check_outs("t4_dwait_beats_redirect", O_FREEZE);
    dmem_req_mem = 1'b0; dhit = 1'b1; redirect_ex = 1'b0; dmemREN_ex = 1'b0; settle();
    check_outs("t4_iwait", O_IWAIT);
    tick();
    check("t4_cnt", {16'd0, stall_cnt}, 32'd6);
    ihit = 1'b1;
    halt_id = 1'b1; settle();
    check_outs("t4_halt_run_cycle", O_NORM);
    tick();
    halt_id = 1'b0; settle();
    check("t4_in_drain", {30'd0, state}, {30'd0, S_DRAIN});
    check_outs("t4_drain_outs", O_DRAIN);
    redirect_ex = 1'b1; settle();
    check_outs("t4_drain_redirect", O_REDIR);
    tick();
    redirect_ex = 1'b0; settle();
    check("t4_back_to_run", {30'd0, state}, {30'd0, S_RUN});
    check_outs("t4_run_pc_en", O_NORM);
    check("t4_cnt2", {16'd0, stall_cnt}, 32'd6);

    // load-use holds a halt in RUN for one cycle
    halt_id = 1'b1; dmemREN_ex = 1'b1; wsel_ex = 5'd3; rs_id = 5'd3; settle();
    tick();
    check("lu_holds_halt", {30'd0, state}, {30'd0, S_RUN});
    dmemREN_ex = 1'b0; settle();
    tick();
    halt_id = 1'b0; settle();
    check("lu_then_drain", {30'd0, state}, {30'd0, S_DRAIN});
    check("lu_cnt", {16'd0, stall_cnt}, 32'd7);

    // T5 drain, dwait in drain, halt
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_outs("t5_drain", O_DRAIN);
      tick();
    end
    check("t5_cnt", {16'd0, stall_cnt}, 32'd10);
    ihit = 1'b1; halt_wb = 1'b1; dmem_req_mem = 1'b1; dhit = 1'b0; settle();
    check_outs("t5_drain_dwait", O_FREEZE);
    tick();
    check("t5_dwait_holds_drain", {30'd0, state}, {30'd0, S_DRAIN});
    dmem_req_mem = 1'b0; dhit = 1'b1; settle();
    check_outs("t5_drain_wb", O_DRAIN);
    tick();
    halt_wb = 1'b0; settle();
    check("t5_halted_state", {30'd0, state}, {30'd0, S_HALTED});
    check_outs("t5_halted_outs", O_HALTED);
    check("t5_cnt_at_halt", {16'd0, stall_cnt}, 32'd12);
    ihit = 1'b0; halt_id = 1'b1; tick(2);
    check_outs("t5_halted_sticky", O_HALTED);
    check("t5_cnt_frozen", {16'd0, stall_cnt}, 32'd12);
    nRST = 1'b0; settle();
    check_outs("t5_reset_outs", O_RST);
    check("t5_reset_cnt", {16'd0, stall_cnt}, 32'd0);
    check("t5_reset_state", {30'd0, state}, {30'd0, S_RUN});
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1; settle();

    // reset aborts mid-DWAIT
    dmem_req_mem = 1'b1; dhit = 1'b0; tick(2);
    check("dwait_cnt", {16'd0, stall_cnt}, 32'd2);
    nRST = 1'b0; settle();
    check_outs("dwait_reset_outs", O_RST);
    check("dwait_reset_cnt", {16'd0, stall_cnt}, 32'd0);
    idle_inputs();
    @(negedge CLK);
    nRST = 1'b1; settle();

    // T6 saturation on the 4-bit counter
    ihit = 1'b0; settle();
    tick(10);
    check("t6_small_10", {28'd0, s_stall_cnt}, 32'd10);
    tick(10);
    check("t6_small_sat", {28'd0, s_stall_cnt}, 32'd15);
    check("t6_wide_20", {16'd0, stall_cnt}, 32'd20);
    ihit = 1'b1; settle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
